// File: rtl/instr_imm_encoder_pkg.sv
// Shared types for the immediate encoder: immediate formats, packer states and
// the reference extender used to prove an encoded immediate round-trips.
package instr_imm_encoder_pkg;

  typedef enum logic [3:0] {
    IMM_I    = 4'd0,
    IMM_S    = 4'd1,
    IMM_B    = 4'd2,
    IMM_U    = 4'd3,
    IMM_J    = 4'd4,
    IMM_CI   = 4'd5,
    IMM_CIW  = 4'd6,
    IMM_CSPL = 4'd7,
    IMM_CSPS = 4'd8,
    IMM_CLS  = 4'd9,
    IMM_CJ   = 4'd10,
    IMM_CB   = 4'd11,
    IMM_CJR  = 4'd12
  } immediate_source_t;

  typedef enum logic {
    PACK_EMPTY = 1'b0,
    PACK_HALF  = 1'b1
  } pack_state_t;

  localparam logic [15:0] C_NOP = 16'h0001;

  // Core extender semantics; the compressed load/store offsets are sign-extended.
  function automatic logic [31:0] extend_imm(input immediate_source_t t, input logic [31:0] i);
    logic [31:0] r;
    case (t)
      IMM_S:    r = {{20{i[31]}}, i[31:25], i[11:7]};
      IMM_B:    r = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      IMM_U:    r = {i[31:12], 12'h000};
      IMM_J:    r = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      IMM_CI:   r = {{26{i[12]}}, i[12], i[6:2]};
      IMM_CIW:  r = {{22{i[10]}}, i[10:7], i[12:11], i[5], i[6], 2'b00};
      IMM_CSPL: r = {{24{i[3]}}, i[3:2], i[12], i[6:4], 2'b00};
      IMM_CSPS: r = {{24{i[8]}}, i[8:7], i[12:9], 2'b00};
      IMM_CLS:  r = {{25{i[5]}}, i[5], i[12:10], i[6], 2'b00};
      IMM_CJ:   r = {{20{i[12]}}, i[12], i[8], i[10:9], i[6], i[7], i[2], i[11], i[5:3], 1'b0};
      IMM_CB:   r = {{23{i[12]}}, i[12], i[6:5], i[2], i[11:10], i[4:3], 1'b0};
      IMM_CJR:  r = 32'h0000_0000;
      default:  r = {{20{i[31]}}, i[31:20]};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/instr_imm_encoder_imm_inserter.sv
// Combinational insertion of an immediate into an instruction template, plus the
// representability check (re-extend the result and compare with the request).
module imm_inserter
  import instr_imm_encoder_pkg::*;
#(
  parameter int DWIDTH = 32
) (
  input  immediate_source_t  i_type,
  input  logic [DWIDTH-1:0]  i_imm,
  input  logic [31:0]        i_template,
  output logic [31:0]        o_instr,
  output logic               o_is_compressed,
  output logic               o_imm_ok
);

  logic [31:0]       w_imm;
  logic [31:0]       w_ext;
  logic [DWIDTH-1:0] w_ext_full;

  assign w_imm = i_imm[31:0];

  // Scatter immediate bits into the fields the extender gathers them from.
  always_comb begin
    o_instr         = i_template;
    o_is_compressed = 1'b1;
    case (i_type)
      IMM_S: begin
        o_is_compressed = 1'b0;
        o_instr[31:25]  = w_imm[11:5];
        o_instr[11:7]   = w_imm[4:0];
      end
      IMM_B: begin
        o_is_compressed = 1'b0;
        o_instr[31]     = w_imm[12];
        o_instr[7]      = w_imm[11];
        o_instr[30:25]  = w_imm[10:5];
        o_instr[11:8]   = w_imm[4:1];
      end
      IMM_U: begin
        o_is_compressed = 1'b0;
        o_instr[31:12]  = w_imm[31:12];
      end
      IMM_J: begin
        o_is_compressed = 1'b0;
        o_instr[31]     = w_imm[20];
        o_instr[19:12]  = w_imm[19:12];
        o_instr[20]     = w_imm[11];
        o_instr[30:21]  = w_imm[10:1];
      end
      IMM_CI: begin
        o_instr[12]     = w_imm[5];
        o_instr[6:2]    = w_imm[4:0];
      end
      IMM_CIW: begin
        o_instr[10:7]   = w_imm[9:6];
        o_instr[12:11]  = w_imm[5:4];
        o_instr[5]      = w_imm[3];
        o_instr[6]      = w_imm[2];
      end
      IMM_CSPL: begin
        o_instr[3:2]    = w_imm[7:6];
        o_instr[12]     = w_imm[5];
        o_instr[6:4]    = w_imm[4:2];
      end
      IMM_CSPS: begin
        o_instr[8:7]    = w_imm[7:6];
        o_instr[12:9]   = w_imm[5:2];
      end
      IMM_CLS: begin
        o_instr[5]      = w_imm[6];
        o_instr[12:10]  = w_imm[5:3];
        o_instr[6]      = w_imm[2];
      end
      IMM_CJ: begin
        o_instr[12]     = w_imm[11];
        o_instr[8]      = w_imm[10];
        o_instr[10:9]   = w_imm[9:8];
        o_instr[6]      = w_imm[7];
        o_instr[7]      = w_imm[6];
        o_instr[2]      = w_imm[5];
        o_instr[11]     = w_imm[4];
        o_instr[5:3]    = w_imm[3:1];
      end
      IMM_CB: begin
        o_instr[12]     = w_imm[8];
        o_instr[6:5]    = w_imm[7:6];
        o_instr[2]      = w_imm[5];
        o_instr[11:10]  = w_imm[4:3];
        o_instr[4:3]    = w_imm[2:1];
      end
      IMM_CJR: begin
        o_is_compressed = 1'b1;
      end
      default: begin
        o_is_compressed = 1'b0;
        o_instr[31:20]  = w_imm[11:0];
      end
    endcase
  end

  // Legal exactly when the extender recovers the full-width request unchanged.
  assign w_ext      = extend_imm(i_type, o_instr);
  assign w_ext_full = DWIDTH'($signed(w_ext));
  assign o_imm_ok   = (w_ext_full == i_imm);

endmodule

// File: rtl/instr_imm_encoder.sv
// Immediate encoder and halfword packer producing a little-endian 32-bit
// instruction-memory write stream with addresses and error accounting.
module instr_imm_encoder
  import instr_imm_encoder_pkg::*;
#(
  parameter int          DWIDTH    = 32,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  immediate_source_t req_type_i,
  input  logic [DWIDTH-1:0] req_imm_i,
  input  logic [31:0]       req_instr_i,
  input  logic              flush_i,
  output logic              word_valid_o,
  input  logic              word_ready_i,
  output logic [31:0]       word_o,
  output logic [31:0]       word_addr_o,
  output logic              err_o,
  output logic [7:0]        err_cnt_o,
  output logic              idle_o
);

  pack_state_t r_state;
  pack_state_t w_state_nxt;
  logic [15:0] r_pending;
  logic [15:0] w_pending_nxt;
  logic        r_word_valid;
  logic [31:0] r_word;
  logic [31:0] r_addr;
  logic        r_err;
  logic [7:0]  r_err_cnt;

  logic [31:0] w_instr;
  logic        w_is_c;
  logic        w_imm_ok;
  logic        w_slot_free;
  logic        w_accept;
  logic        w_good;
  logic        w_bad;
  logic        w_flush_go;
  logic        w_emit;
  logic [31:0] w_emit_word;

  imm_inserter #(.DWIDTH(DWIDTH)) u_inserter (
    .i_type          (req_type_i),
    .i_imm           (req_imm_i),
    .i_template      (req_instr_i),
    .o_instr         (w_instr),
    .o_is_compressed (w_is_c),
    .o_imm_ok        (w_imm_ok)
  );

  assign w_slot_free = !r_word_valid || word_ready_i;
  assign req_ready_o = !flush_i && w_slot_free;
  assign w_accept    = req_valid_i && req_ready_o;
  assign w_good      = w_accept && w_imm_ok;
  assign w_bad       = w_accept && !w_imm_ok;
  assign w_flush_go  = flush_i && (r_state == PACK_HALF) && w_slot_free;

  // Packer next-state: flush has priority, and requests are already blocked by it.
  always_comb begin
    w_state_nxt   = r_state;
    w_pending_nxt = r_pending;
    w_emit        = 1'b0;
    w_emit_word   = 32'h0000_0000;
    if (w_flush_go) begin
      w_emit      = 1'b1;
      w_emit_word = {C_NOP, r_pending};
      w_state_nxt = PACK_EMPTY;
    end else if (w_good) begin
      case (r_state)
        PACK_EMPTY: begin
          if (w_is_c) begin
            w_pending_nxt = w_instr[15:0];
            w_state_nxt   = PACK_HALF;
          end else begin
            w_emit      = 1'b1;
            w_emit_word = w_instr;
          end
        end
        PACK_HALF: begin
          w_emit      = 1'b1;
          w_emit_word = {w_instr[15:0], r_pending};
          if (w_is_c) begin
            w_state_nxt = PACK_EMPTY;
          end else begin
            w_pending_nxt = w_instr[31:16];
          end
        end
        default: begin
          w_state_nxt = PACK_EMPTY;
        end
      endcase
    end else begin
      w_state_nxt = r_state;
    end
  end

  // Packer state and pending halfword.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= PACK_EMPTY;
      r_pending <= 16'h0000;
    end else begin
      r_state   <= w_state_nxt;
      r_pending <= w_pending_nxt;
    end
  end

  // Single output register; holds while the sink stalls.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_word_valid <= 1'b0;
      r_word       <= 32'h0000_0000;
    end else if (w_emit) begin
      r_word_valid <= 1'b1;
      r_word       <= w_emit_word;
    end else if (word_ready_i) begin
      r_word_valid <= 1'b0;
    end
  end

  // Byte address advances once per completed output handshake.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_addr <= BASE_ADDR;
    end else if (r_word_valid && word_ready_i) begin
      r_addr <= r_addr + 32'd4;
    end
  end

  // Error pulse and saturating error count.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_err     <= 1'b0;
      r_err_cnt <= 8'h00;
    end else begin
      r_err <= w_bad;
      if (w_bad && (r_err_cnt != 8'hFF)) begin
        r_err_cnt <= r_err_cnt + 8'd1;
      end
    end
  end

  assign word_valid_o = r_word_valid;
  assign word_o       = r_word;
  assign word_addr_o  = r_addr;
  assign err_o        = r_err;
  assign err_cnt_o    = r_err_cnt;
  assign idle_o       = (r_state == PACK_EMPTY) && !r_word_valid;

endmodule

// File: tb/tb_instr_imm_encoder.sv
// Scoreboard bench: a halfword-stream model predicts every emitted word and error
// pulse; a negedge monitor pops and compares whenever the DUT hands something out.
`timescale 1ns/1ps
module tb_instr_imm_encoder;
  import instr_imm_encoder_pkg::*;

  localparam logic [31:0] BASE = 32'h8000_0100;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              req_valid_i;
  logic              req_ready_o;
  immediate_source_t req_type_i;
  logic [31:0]       req_imm_i;
  logic [31:0]       req_instr_i;
  logic              flush_i;
  logic              word_valid_o;
  logic              word_ready_i;
  logic [31:0]       word_o;
  logic [31:0]       word_addr_o;
  logic              err_o;
  logic [7:0]        err_cnt_o;
  logic              idle_o;

  instr_imm_encoder #(.DWIDTH(32), .BASE_ADDR(BASE)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_type_i(req_type_i), .req_imm_i(req_imm_i), .req_instr_i(req_instr_i),
    .flush_i(flush_i), .word_valid_o(word_valid_o), .word_ready_i(word_ready_i),
    .word_o(word_o), .word_addr_o(word_addr_o), .err_o(err_o), .err_cnt_o(err_cnt_o),
    .idle_o(idle_o)
  );

  always #5 clk_i = ~clk_i;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [15:0] hw_q[$];
  logic [31:0] exp_words[$];
  logic [7:0]  err_q[$];
  logic [7:0]  err_exp = 8'h00;
  logic [31:0] exp_addr = BASE;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // The core's extender, straight from the format definitions.
  function automatic logic [31:0] ref_extend(input logic [3:0] t, input logic [31:0] i);
    case (t)
      IMM_S:    return {{20{i[31]}}, i[31:25], i[11:7]};
      IMM_B:    return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      IMM_U:    return {i[31:12], 12'h000};
      IMM_J:    return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      IMM_CI:   return {{26{i[12]}}, i[12], i[6:2]};
      IMM_CIW:  return {{22{i[10]}}, i[10:7], i[12:11], i[5], i[6], 2'b00};
      IMM_CSPL: return {{24{i[3]}}, i[3:2], i[12], i[6:4], 2'b00};
      IMM_CSPS: return {{24{i[8]}}, i[8:7], i[12:9], 2'b00};
      IMM_CLS:  return {{25{i[5]}}, i[5], i[12:10], i[6], 2'b00};
      IMM_CJ:   return {{20{i[12]}}, i[12], i[8], i[10:9], i[6], i[7], i[2], i[11], i[5:3], 1'b0};
      IMM_CB:   return {{23{i[12]}}, i[12], i[6:5], i[2], i[11:10], i[4:3], 1'b0};
      IMM_CJR:  return 32'h0;
      default:  return {{20{i[31]}}, i[31:20]};
    endcase
  endfunction

  // Encoding by inverting the extender: probe each instruction bit for the imm bit it feeds.
  function automatic logic [31:0] ref_encode(input logic [3:0] t, input logic [31:0] tmpl,
                                             input logic [31:0] imm);
    logic [31:0] r, probe, e;
    int k;
    r = tmpl;
    for (int b = 0; b < 32; b++) begin
      probe = 32'h0;
      probe[b] = 1'b1;
      e = ref_extend(t, probe);
      if (e != 32'h0) begin
        k = 0;
        for (int j = 31; j >= 0; j--) if (e[j]) k = j;
        r[b] = imm[k];
      end
    end
    return r;
  endfunction

  // Signed field width and alignment of each format (32 = U, 0 = CJR).
  function automatic void ref_fmt(input logic [3:0] t, output int bits, output int align);
    case (t)
      IMM_S:    begin bits = 12; align = 1; end
      IMM_B:    begin bits = 13; align = 2; end
      IMM_U:    begin bits = 32; align = 4096; end
      IMM_J:    begin bits = 21; align = 2; end
      IMM_CI:   begin bits = 6;  align = 1; end
      IMM_CIW:  begin bits = 10; align = 4; end
      IMM_CSPL: begin bits = 8;  align = 4; end
      IMM_CSPS: begin bits = 8;  align = 4; end
      IMM_CLS:  begin bits = 7;  align = 4; end
      IMM_CJ:   begin bits = 12; align = 2; end
      IMM_CB:   begin bits = 9;  align = 2; end
      IMM_CJR:  begin bits = 0;  align = 1; end
      default:  begin bits = 12; align = 1; end
    endcase
  endfunction

  function automatic bit ref_legal(input logic [3:0] t, input logic [31:0] imm);
    int bits, align;
    longint s, half;
    ref_fmt(t, bits, align);
    if (bits == 0) return imm == 32'h0;
    if (bits == 32) return imm[11:0] == 12'h000;
    s = longint'($signed(imm));
    half = longint'(1) << (bits - 1);
    return (s >= -half) && (s < half) && ((imm & 32'(align - 1)) == 32'h0);
  endfunction

  function automatic logic [31:0] gen_imm(input logic [3:0] t);
    int bits, align;
    longint s, half;
    ref_fmt(t, bits, align);
    if ($urandom_range(0, 7) == 0) return $urandom;
    if (bits == 0) return 32'h0;
    if (bits == 32) return $urandom & 32'hFFFF_F000;
    half = longint'(1) << (bits - 1);
    case ($urandom_range(0, 4))
      0:       s = -half;
      1:       s = half - longint'(align);
      2:       s = half;
      default: s = longint'($urandom_range(0, (1 << bits) - 1)) - half;
    endcase
    return 32'(s) & ~32'(align - 1);
  endfunction

  function automatic void model_pack();
    logic [15:0] lo, hi;
    while (hw_q.size() >= 2) begin
      lo = hw_q.pop_front();
      hi = hw_q.pop_front();
      exp_words.push_back({hi, lo});
    end
  endfunction

  function automatic void model_accept(input logic [3:0] t, input logic [31:0] imm,
                                       input logic [31:0] ins);
    logic [3:0]  te;
    logic [31:0] enc;
    te = (t > 4'd12) ? 4'd0 : t;
    if (ref_legal(te, imm)) begin
      enc = ref_encode(te, ins, imm);
      hw_q.push_back(enc[15:0]);
      if (te inside {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J}) hw_q.push_back(enc[31:16]);
      model_pack();
    end else begin
      if (err_exp != 8'hFF) err_exp = err_exp + 8'd1;
      err_q.push_back(err_exp);
    end
  endfunction

  // Apply one cycle of inputs just after the edge; the model commits what the next edge accepts.
  task automatic drive(input bit v, input logic [3:0] t, input logic [31:0] imm,
                       input logic [31:0] ins, input bit fl, input bit rdy);
    bit exp_rdy;
    @(posedge clk_i);
    #1;
    req_valid_i  = v;
    req_type_i   = immediate_source_t'(t);
    req_imm_i    = imm;
    req_instr_i  = ins;
    flush_i      = fl;
    word_ready_i = rdy;
    #1;
    exp_rdy = !fl && (!word_valid_o || rdy);
    check32("req_ready", {31'h0, req_ready_o}, {31'h0, exp_rdy});
    if (v && exp_rdy) model_accept(t, imm, ins);
    if (fl && (hw_q.size() == 1) && (!word_valid_o || rdy)) begin
      hw_q.push_back(C_NOP);
      model_pack();
    end
  endtask

  task automatic idle(input bit rdy);
    drive(1'b0, 4'd0, 32'h0, 32'h0, 1'b0, rdy);
  endtask

  // Monitor: every output handshake and every error pulse is popped and compared.
  always @(negedge clk_i) begin
    if (rst_i === 1'b0) begin
      if (word_valid_o && word_ready_i) begin
        if (exp_words.size() == 0) check32("unexpected_word", word_o, 32'hxxxx_xxxx);
        else check32("word", word_o, exp_words.pop_front());
        check32("word_addr", word_addr_o, exp_addr);
        exp_addr = exp_addr + 32'd4;
      end
      if (err_o) begin
        if (err_q.size() == 0) check32("unexpected_err", {24'h0, err_cnt_o}, 32'hxxxx_xxxx);
        else check32("err_cnt_pulse", {24'h0, err_cnt_o}, {24'h0, err_q.pop_front()});
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $finish;
  end

  task automatic reset_checks();
    check32("rst_word_valid", {31'h0, word_valid_o}, 32'h0);
    check32("rst_word", word_o, 32'h0);
    check32("rst_addr", word_addr_o, BASE);
    check32("rst_err", {31'h0, err_o}, 32'h0);
    check32("rst_err_cnt", {24'h0, err_cnt_o}, 32'h0);
    check32("rst_idle", {31'h0, idle_o}, 32'h1);
  endtask

  initial begin
    logic [3:0] t;
    bit v, fl, rdy;
    rst_i = 1'b1; req_valid_i = 1'b0; req_type_i = IMM_I; req_imm_i = 32'h0;
    req_instr_i = 32'h0; flush_i = 1'b0; word_ready_i = 1'b1;
    #12;
    reset_checks();
    @(negedge clk_i); rst_i = 1'b0;

    // I-type all-ones immediate, one cycle after the handshake
    drive(1'b1, IMM_I, 32'hFFFF_FFFF, 32'h0000_0013, 1'b0, 1'b1);
    idle(1'b1);
    @(negedge clk_i);
    check32("t1_valid", {31'h0, word_valid_o}, 32'h1);
    check32("t1_word", word_o, 32'hFFF0_0013);
    check32("t1_addr", word_addr_o, BASE);

    // Two unrepresentable immediates
    drive(1'b1, IMM_B, 32'h0000_0801, 32'h0000_0063, 1'b0, 1'b1);
    drive(1'b1, IMM_I, 32'h0000_0800, 32'h0000_0013, 1'b0, 1'b1);
    idle(1'b1);
    @(negedge clk_i);
    check32("t2_err_cnt", {24'h0, err_cnt_o}, 32'd2);
    check32("t2_idle", {31'h0, idle_o}, 32'h1);

    // Two compressed CI instructions fill one word
    drive(1'b1, IMM_CI, 32'd5, 32'h0000_4501, 1'b0, 1'b1);
    drive(1'b1, IMM_CI, 32'hFFFF_FFFF, 32'h0000_4501, 1'b0, 1'b1);
    idle(1'b1);
    @(negedge clk_i);
    check32("t3_word", word_o, 32'h557D_4515);
    check32("t3_addr", word_addr_o, BASE + 32'd4);

    // CI, straddling 32-bit, then flush pads with C.NOP
    drive(1'b1, IMM_CI, 32'd5, 32'h0000_4501, 1'b0, 1'b1);
    drive(1'b1, IMM_I, 32'hFFFF_FFFF, 32'h0000_0013, 1'b0, 1'b1);
    drive(1'b0, 4'd0, 32'h0, 32'h0, 1'b1, 1'b1);
    @(negedge clk_i);
    check32("t4_word0", word_o, 32'h0013_4515);
    idle(1'b1);
    @(negedge clk_i);
    check32("t4_word1", word_o, 32'h0001_FFF0);
    check32("t4_addr1", word_addr_o, BASE + 32'd12);
    idle(1'b1);
    @(negedge clk_i);
    check32("t4_idle", {31'h0, idle_o}, 32'h1);

    // Backpressure: output held stable, requests blocked, then released
    drive(1'b1, IMM_I, 32'd1, 32'h0000_0013, 1'b0, 1'b0);
    for (int s = 0; s < 3; s++) begin
      drive(1'b1, IMM_I, 32'd7, 32'h0000_0013, 1'b0, 1'b0);
      @(negedge clk_i);
      check32("t5_hold_word", word_o, 32'h0010_0013);
      check32("t5_hold_addr", word_addr_o, BASE + 32'd16);
    end
    drive(1'b1, IMM_I, 32'd2, 32'h0000_0013, 1'b0, 1'b1);
    idle(1'b1);
    @(negedge clk_i);
    check32("t5_next_word", word_o, 32'h0020_0013);
    check32("t5_next_addr", word_addr_o, BASE + 32'd20);

    // Asynchronous reset while HALF with a stalled valid word
    drive(1'b1, IMM_CI, 32'd5, 32'h0000_4501, 1'b0, 1'b1);
    drive(1'b1, IMM_I, 32'hFFFF_FFFF, 32'h0000_0013, 1'b0, 1'b0);
    idle(1'b0);
    #2 rst_i = 1'b1;
    #1;
    reset_checks();
    hw_q.delete(); exp_words.delete(); err_q.delete();
    err_exp = 8'h00; exp_addr = BASE;
    #1 rst_i = 1'b0;
    drive(1'b1, IMM_CI, 32'd5, 32'h0000_4501, 1'b0, 1'b1);
    drive(1'b1, IMM_CI, 32'hFFFF_FFFF, 32'h0000_4501, 1'b0, 1'b1);
    idle(1'b1);
    @(negedge clk_i);
    check32("t6_word", word_o, 32'h557D_4515);
    check32("t6_addr", word_addr_o, BASE);

    // Randomized traffic with backpressure, flushes and unknown formats
    for (int n = 0; n < 3000; n++) begin
      t   = 4'($urandom_range(0, 15));
      v   = ($urandom_range(0, 9) < 7);
      fl  = ($urandom_range(0, 9) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      drive(v, t, gen_imm((t > 4'd12) ? 4'd0 : t), $urandom, fl, rdy);
    end
    for (int n = 0; n < 3; n++) drive(1'b0, 4'd0, 32'h0, 32'h0, 1'b1, 1'b1);
    for (int n = 0; n < 3; n++) idle(1'b1);

    // Error counter saturates at 255
    for (int n = 0; n < 260; n++) drive(1'b1, IMM_CJR, 32'd1, 32'h0000_8082, 1'b0, 1'b1);
    for (int n = 0; n < 3; n++) idle(1'b1);
    @(negedge clk_i);
    check32("sat_err_cnt", {24'h0, err_cnt_o}, 32'd255);
    check32("end_err_cnt", {24'h0, err_cnt_o}, {24'h0, err_exp});
    check32("end_idle", {31'h0, idle_o}, 32'h1);
    check32("end_words_left", exp_words.size(), 32'd0);
    check32("end_errs_left", err_q.size(), 32'd0);
    check32("end_halfwords_left", hw_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
